// File: rtl/collatz_host_driver_pkg.sv
// Shared definitions for the Collatz peripheral pin protocol: pin bit positions,
// the overflow marker value and the host FSM state encoding.
package collatz_host_driver_pkg;

  localparam int unsigned PIN_W         = 8;
  localparam int unsigned SEED_W        = 32;
  localparam int unsigned ORBIT_W       = 16;
  localparam int unsigned PATH_W        = 32;
  localparam int unsigned WE_BIT        = 7;
  localparam int unsigned START_BIT     = 6;
  localparam int unsigned PSEL_BIT      = 4;
  localparam int unsigned ADDR_W        = 4;
  localparam int unsigned OE_COMPUTE    = 7;
  localparam int unsigned N_SEED_BYTES  = 4;
  localparam int unsigned N_ORBIT_BYTES = 2;
  localparam int unsigned N_READ_SLOTS  = 6;

  localparam logic [PATH_W-1:0] OVERFLOW_MAGIC = 32'hBAADF00D;
  localparam logic [PIN_W-1:0]  START_PINS     = PIN_W'(1 << START_BIT);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_START,
    ST_WAIT_ENTER,
    ST_WAIT_EXIT,
    ST_READ_SET,
    ST_READ_CAP,
    ST_FINISH
  } state_e;

  // Pin pattern for writing seed byte idx.
  function automatic logic [PIN_W-1:0] write_pins(input logic [1:0] idx);
    logic [PIN_W-1:0] p;
    p             = '0;
    p[WE_BIT]     = 1'b1;
    p[ADDR_W-1:0] = ADDR_W'(idx);
    return p;
  endfunction

  // Pin pattern for read slot: orbit bytes first, then path bytes.
  function automatic logic [PIN_W-1:0] read_pins(input logic [2:0] slot);
    logic [PIN_W-1:0] p;
    p = '0;
    if (slot < 3'(N_ORBIT_BYTES)) begin
      p[ADDR_W-1:0] = ADDR_W'(slot);
    end else begin
      p[PSEL_BIT]   = 1'b1;
      p[ADDR_W-1:0] = ADDR_W'(slot - 3'(N_ORBIT_BYTES));
    end
    return p;
  endfunction

endpackage

// File: rtl/collatz_host_driver_if.sv
// Request/result handshake plus the peripheral pin bundle seen by the host driver.
interface collatz_host_driver_if;
  import collatz_host_driver_pkg::*;

  logic                 req_valid;
  logic [SEED_W-1:0]    req_seed;
  logic                 busy;
  logic                 done;
  logic                 error;
  logic                 overflow;
  logic [ORBIT_W-1:0]   orbit_len;
  logic [PATH_W-1:0]    path_record;
  logic [PIN_W-1:0]     dev_ui_in;
  logic [PIN_W-1:0]     dev_uio_in;
  logic [PIN_W-1:0]     dev_uo_out;
  logic [PIN_W-1:0]     dev_uio_out;
  logic [PIN_W-1:0]     dev_uio_oe;

  modport master (
    input  req_valid, req_seed, dev_uo_out, dev_uio_out, dev_uio_oe,
    output busy, done, error, overflow, orbit_len, path_record, dev_ui_in, dev_uio_in
  );

  modport slave (
    output req_valid, req_seed, dev_uo_out, dev_uio_out, dev_uio_oe,
    input  busy, done, error, overflow, orbit_len, path_record, dev_ui_in, dev_uio_in
  );

endinterface

// File: rtl/collatz_host_watchdog.sv
// Loadable, clearable saturating up-counter; terminal_c flags the all-ones count.
module collatz_host_watchdog #(
  parameter int unsigned WIDTH = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             enable,
  output logic             terminal_c
);

  logic [WIDTH-1:0] count;

  assign terminal_c = &count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (enable && !terminal_c) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/collatz_host_driver.sv
// Host master for the Collatz peripheral: writes the seed, pulses start, waits out
// COMPUTE under a watchdog, then reads back orbit length and path record.
module collatz_host_driver
  import collatz_host_driver_pkg::*;
#(
  parameter int unsigned ENTER_TIMEOUT    = 8,
  parameter int unsigned RUN_TIMEOUT_BITS = 24
) (
  input logic                  clk,
  input logic                  reset,
  collatz_host_driver_if.master bus
);

  // Preloading to (all-ones - ENTER_TIMEOUT + 1) lets the same counter expire after ENTER_TIMEOUT cycles.
  localparam logic [RUN_TIMEOUT_BITS-1:0] ENTER_LOAD =
    RUN_TIMEOUT_BITS'((64'(1) << RUN_TIMEOUT_BITS) - 64'(ENTER_TIMEOUT));

  state_e                       state, state_n;
  logic [N_SEED_BYTES-1:0][7:0] seed_q, seed_n;
  logic [1:0]                   idx, idx_n;
  logic [2:0]                   slot, slot_n;
  logic [N_READ_SLOTS-1:0][7:0] shadow, shadow_n;
  logic                         busy_q, busy_n;
  logic                         done_q, done_n;
  logic                         error_q, error_n;
  logic                         overflow_q, overflow_n;
  logic [ORBIT_W-1:0]           orbit_q, orbit_n;
  logic [PATH_W-1:0]            path_q, path_n;
  logic [PIN_W-1:0]             ui_q, ui_n;
  logic [PIN_W-1:0]             uio_q, uio_n;
  logic                         wd_clear, wd_load, wd_en, wd_term;

  collatz_host_watchdog #(.WIDTH(RUN_TIMEOUT_BITS)) u_watchdog (
    .clk        (clk),
    .reset      (reset),
    .clear      (wd_clear),
    .load       (wd_load),
    .load_val   (ENTER_LOAD),
    .enable     (wd_en),
    .terminal_c (wd_term)
  );

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.error       = error_q;
  assign bus.overflow    = overflow_q;
  assign bus.orbit_len   = orbit_q;
  assign bus.path_record = path_q;
  assign bus.dev_ui_in   = ui_q;
  assign bus.dev_uio_in  = uio_q;

  // Next-state and next-output logic; pin values are computed for the state being entered.
  always_comb begin
    state_n    = state;
    seed_n     = seed_q;
    idx_n      = idx;
    slot_n     = slot;
    shadow_n   = shadow;
    busy_n     = busy_q;
    done_n     = 1'b0;
    error_n    = 1'b0;
    overflow_n = overflow_q;
    orbit_n    = orbit_q;
    path_n     = path_q;
    ui_n       = '0;
    uio_n      = '0;
    wd_clear   = 1'b0;
    wd_load    = 1'b0;
    wd_en      = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          state_n = ST_WRITE;
          seed_n  = bus.req_seed;
          busy_n  = 1'b1;
          idx_n   = 2'd0;
          uio_n   = write_pins(2'd0);
          ui_n    = bus.req_seed[7:0];
        end
      end
      ST_WRITE: begin
        if (idx == 2'(N_SEED_BYTES - 1)) begin
          state_n = ST_START;
          uio_n   = START_PINS;
        end else begin
          idx_n = idx + 2'd1;
          uio_n = write_pins(idx_n);
          ui_n  = seed_q[idx_n];
        end
      end
      ST_START: begin
        state_n = ST_WAIT_ENTER;
        wd_load = 1'b1;
      end
      ST_WAIT_ENTER: begin
        wd_en = 1'b1;
        if (bus.dev_uio_oe[OE_COMPUTE]) begin
          state_n  = ST_WAIT_EXIT;
          wd_clear = 1'b1;
        end else if (wd_term) begin
          state_n = ST_FINISH;
          done_n  = 1'b1;
          error_n = 1'b1;
        end
      end
      ST_WAIT_EXIT: begin
        wd_en = 1'b1;
        if (!bus.dev_uio_oe[OE_COMPUTE]) begin
          state_n = ST_READ_SET;
          slot_n  = 3'd0;
          uio_n   = read_pins(3'd0);
        end else if (wd_term) begin
          state_n = ST_FINISH;
          done_n  = 1'b1;
          error_n = 1'b1;
        end
      end
      ST_READ_SET: begin
        state_n = ST_READ_CAP;
        uio_n   = read_pins(slot);
      end
      ST_READ_CAP: begin
        shadow_n[slot] = bus.dev_uo_out;
        if (slot == 3'(N_READ_SLOTS - 1)) begin
          state_n    = ST_FINISH;
          done_n     = 1'b1;
          orbit_n    = shadow_n[1:0];
          path_n     = shadow_n[5:2];
          overflow_n = (shadow_n[5:2] == OVERFLOW_MAGIC);
        end else begin
          slot_n  = slot + 3'd1;
          state_n = ST_READ_SET;
          uio_n   = read_pins(slot_n);
        end
      end
      ST_FINISH: begin
        state_n = ST_IDLE;
        busy_n  = 1'b0;
      end
      default: begin
        state_n = ST_IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      seed_q     <= '0;
      idx        <= '0;
      slot       <= '0;
      shadow     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      overflow_q <= 1'b0;
      orbit_q    <= '0;
      path_q     <= '0;
      ui_q       <= '0;
      uio_q      <= '0;
    end else begin
      state      <= state_n;
      seed_q     <= seed_n;
      idx        <= idx_n;
      slot       <= slot_n;
      shadow     <= shadow_n;
      busy_q     <= busy_n;
      done_q     <= done_n;
      error_q    <= error_n;
      overflow_q <= overflow_n;
      orbit_q    <= orbit_n;
      path_q     <= path_n;
      ui_q       <= ui_n;
      uio_q      <= uio_n;
    end
  end

endmodule

// File: tb/tb_collatz_host_driver.sv
// Bench for collatz_host_driver with a behavioural Collatz peripheral stub and an
// arithmetic reference model of orbit length / path record.
module tb_collatz_host_driver;
  import collatz_host_driver_pkg::*;

  localparam int unsigned ENTER_TO = 8;
  localparam int unsigned RUN_BITS = 6;

  logic clk = 1'b0;
  logic reset;
  logic stuck_oe;

  always #5 clk = ~clk;

  collatz_host_driver_if ifc();

  collatz_host_driver #(
    .ENTER_TIMEOUT    (ENTER_TO),
    .RUN_TIMEOUT_BITS (RUN_BITS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  // Peripheral stub: up to 8 Collatz steps per cycle, orbit never cleared, sticky overflow.
  typedef struct packed {
    logic [31:0] n;
    logic [31:0] peak;
    logic [15:0] orbit;
    logic        fin;
    logic        ovf;
  } burst_t;

  function automatic burst_t run_burst(input logic [31:0] n, input logic [31:0] peak,
                                       input logic [15:0] orbit);
    burst_t      r;
    logic [33:0] t;
    r.n = n; r.peak = peak; r.orbit = orbit; r.ovf = 1'b0; r.fin = 1'b0;
    for (int s = 0; s < 8; s++) begin
      if (!r.ovf && r.n != 32'd1) begin
        if (!r.n[0]) begin
          r.n = r.n >> 1;
        end else begin
          t = {2'b00, r.n} * 34'd3 + 34'd1;
          if (t[33:32] != 2'b00) r.ovf = 1'b1;
          else r.n = t[31:0];
        end
        if (!r.ovf) begin
          r.orbit = r.orbit + 16'd1;
          if (r.n > r.peak) r.peak = r.n;
        end
      end
    end
    r.fin = r.ovf || (r.n == 32'd1);
    return r;
  endfunction

  logic [3:0][7:0] p_seed;
  logic [31:0]     p_n, p_peak;
  logic [3:0][7:0] p_path;
  logic [1:0][7:0] p_orbit;
  logic            p_compute, p_ovf;
  logic [7:0]      p_uo;
  burst_t          nb;

  always_comb nb = run_burst(p_n, p_peak, p_orbit);

  always @(posedge clk) begin
    if (reset) begin
      p_seed <= '0; p_n <= '0; p_peak <= '0; p_path <= '0; p_orbit <= '0;
      p_compute <= 1'b0; p_ovf <= 1'b0; p_uo <= '0;
    end else begin
      if (p_compute) begin
        p_n <= nb.n; p_peak <= nb.peak; p_orbit <= nb.orbit;
        if (nb.fin) begin
          p_compute <= 1'b0;
          p_ovf     <= nb.ovf;
          p_path    <= nb.ovf ? 32'hBAADF00D : nb.peak;
        end
      end else begin
        if (ifc.dev_uio_in[7]) p_seed[ifc.dev_uio_in[1:0]] <= ifc.dev_ui_in;
        if (ifc.dev_uio_in[6] && !p_ovf) begin
          p_compute <= 1'b1; p_n <= p_seed; p_peak <= p_seed;
        end
      end
      p_uo <= ifc.dev_uio_in[4] ? p_path[ifc.dev_uio_in[1:0]] : p_orbit[ifc.dev_uio_in[0]];
    end
  end

  assign ifc.dev_uo_out  = p_uo;
  assign ifc.dev_uio_oe  = {p_compute | stuck_oe, 7'b0};
  assign ifc.dev_uio_out = {p_compute, 7'b0};

  // Pin/handshake monitor.
  int          n_wr = 0, n_start = 0, n_rise = 0, n_done = 0, n_bad = 0;
  logic        prev_busy = 1'b0;
  logic [15:0] wr_log[$];

  always @(negedge clk) begin
    if (ifc.dev_uio_in[7]) begin
      n_wr <= n_wr + 1;
      wr_log.push_back({ifc.dev_uio_in, ifc.dev_ui_in});
    end
    if (ifc.dev_uio_in[6]) n_start <= n_start + 1;
    if (ifc.busy && !prev_busy) n_rise <= n_rise + 1;
    if (ifc.done) n_done <= n_done + 1;
    if ((ifc.done && !ifc.busy) || (ifc.error && !ifc.done) ||
        ifc.dev_uio_oe[6:0] != 7'd0 || ifc.dev_uio_out[6:0] != 7'd0)
      n_bad <= n_bad + 1;
    prev_busy <= ifc.busy;
  end

  int checks = 0, failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic Collatz walk, counting steps until 1 or 32-bit overflow.
  function automatic void ref_collatz(input logic [31:0] seed, output int unsigned steps,
                                      output logic [31:0] path, output bit ovf);
    longint unsigned n, peak;
    n = seed; peak = seed; steps = 0; ovf = 0;
    while (n != 1) begin
      n = (n % 2 == 0) ? n / 2 : 3 * n + 1;
      if (n > 64'hFFFF_FFFF) begin ovf = 1; break; end
      steps++;
      if (n > peak) peak = n;
    end
    path = ovf ? 32'hBAADF00D : peak[31:0];
  endfunction

  task automatic do_req(input logic [31:0] seed, output int lat, output bit ok);
    @(negedge clk);
    ifc.req_valid = 1'b1;
    ifc.req_seed  = seed;
    lat = 0; ok = 0;
    while (lat < 400 && !ok) begin
      @(negedge clk);
      ifc.req_valid = 1'b0;
      lat++;
      if (ifc.done) ok = 1;
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int          lat, w0, s0, d0, r0, rises;
    bit          ok, ov;
    int unsigned st;
    logic [31:0] pk, sd;
    logic [15:0] acc;

    reset = 1'b1; stuck_oe = 1'b0;
    ifc.req_valid = 1'b0; ifc.req_seed = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", ifc.busy, 0);
    check("rst_done", ifc.done, 0);
    check("rst_error", ifc.error, 0);
    check("rst_overflow", ifc.overflow, 0);
    check("rst_orbit", ifc.orbit_len, 0);
    check("rst_path", ifc.path_record, 0);
    check("rst_ui_in", ifc.dev_ui_in, 0);
    check("rst_uio_in", ifc.dev_uio_in, 0);
    reset = 1'b0;
    acc = '0;

    // Seed 6: pin sequence and first result.
    w0 = wr_log.size(); s0 = n_start; sd = 32'd6;
    do_req(sd, lat, ok);
    ref_collatz(sd, st, pk, ov); acc = acc + 16'(st);
    check("t1_done_seen", ok, 1);
    check("t1_error", ifc.error, 0);
    check("t1_orbit", ifc.orbit_len, 16'd8);
    check("t1_path", ifc.path_record, 32'd16);
    check("t1_overflow", ifc.overflow, 0);
    check("t1_busy_at_done", ifc.busy, 1);
    @(negedge clk);
    check("t1_busy_after", ifc.busy, 0);
    check("t1_start_pulses", n_start - s0, 1);
    check("t1_write_count", wr_log.size() - w0, 4);
    for (int i = 0; i < 4; i++)
      check("t1_write_pins", wr_log[w0 + i], {8'(8'h80 + i), sd[i*8 +: 8]});

    // Second identical request: orbit accumulates in the peripheral.
    d0 = n_done;
    do_req(32'd6, lat, ok);
    ref_collatz(32'd6, st, pk, ov); acc = acc + 16'(st);
    check("t2_done_seen", ok, 1);
    check("t2_orbit", ifc.orbit_len, 16'd16);
    check("t2_path", ifc.path_record, 32'd16);
    @(negedge clk);
    check("t2_done_once", n_done - d0, 1);

    // Random seeds against the reference.
    for (int r = 0; r < 6; r++) begin
      sd = 32'($urandom_range(4095, 2));
      do_req(sd, lat, ok);
      ref_collatz(sd, st, pk, ov); acc = acc + 16'(st);
      check("rnd_done_seen", ok, 1);
      check("rnd_error", ifc.error, 0);
      check("rnd_orbit", ifc.orbit_len, acc);
      check("rnd_path", ifc.path_record, pk);
      check("rnd_overflow", ifc.overflow, ov);
    end

    // Overflow seed, then sticky overflow blocks the next start.
    do_req(32'hFFFF_FFFF, lat, ok);
    ref_collatz(32'hFFFF_FFFF, st, pk, ov); acc = acc + 16'(st);
    check("ovf_done_seen", ok, 1);
    check("ovf_path", ifc.path_record, 32'hBAADF00D);
    check("ovf_overflow", ifc.overflow, 1);
    check("ovf_error", ifc.error, 0);
    check("ovf_orbit", ifc.orbit_len, acc);
    do_req(32'd6, lat, ok);
    check("enter_to_done_seen", ok, 1);
    check("enter_to_error", ifc.error, 1);
    check("enter_to_latency", lat, 4 + 1 + ENTER_TO + 1);
    check("enter_to_orbit_kept", ifc.orbit_len, acc);
    check("enter_to_path_kept", ifc.path_record, 32'hBAADF00D);
    check("enter_to_overflow_kept", ifc.overflow, 1);

    // Reset while waiting for COMPUTE to end.
    pulse_reset();
    stuck_oe = 1'b1;
    d0 = n_done;
    @(negedge clk); ifc.req_valid = 1'b1; ifc.req_seed = 32'd6;
    @(negedge clk); ifc.req_valid = 1'b0;
    repeat (12) @(negedge clk);
    check("midrst_busy_before", ifc.busy, 1);
    check("midrst_uio_wait_exit", ifc.dev_uio_in, 0);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_busy", ifc.busy, 0);
    check("midrst_uio_in", ifc.dev_uio_in, 0);
    reset = 1'b0; stuck_oe = 1'b0;
    repeat (5) @(negedge clk);
    check("midrst_no_done", n_done - d0, 0);
    do_req(32'd6, lat, ok);
    check("postrst_done_seen", ok, 1);
    check("postrst_error", ifc.error, 0);
    check("postrst_orbit", ifc.orbit_len, 16'd8);
    check("postrst_path", ifc.path_record, 32'd16);

    // COMPUTE never ends: run watchdog expires.
    stuck_oe = 1'b1;
    do_req(32'd6, lat, ok);
    check("run_to_done_seen", ok, 1);
    check("run_to_error", ifc.error, 1);
    check("run_to_latency_window",
          (lat >= 4 + 1 + (1 << RUN_BITS) - 1) && (lat <= 4 + 1 + ENTER_TO + (1 << RUN_BITS) + 2), 1);
    check("run_to_orbit_kept", ifc.orbit_len, 16'd8);
    check("run_to_path_kept", ifc.path_record, 32'd16);
    stuck_oe = 1'b0;

    // req_valid held high: one transaction per IDLE visit.
    pulse_reset();
    @(negedge clk);
    r0 = n_rise; d0 = n_done; w0 = n_wr; s0 = n_start;
    ifc.req_valid = 1'b1; ifc.req_seed = 32'd6;
    repeat (80) @(negedge clk);
    ifc.req_valid = 1'b0;
    lat = 0;
    while (ifc.busy && lat < 200) begin @(negedge clk); lat++; end
    check("hold_went_idle", ifc.busy, 0);
    repeat (2) @(negedge clk);
    rises = n_rise - r0;
    check("hold_multiple_txn", rises >= 2, 1);
    check("hold_done_per_txn", n_done - d0, rises);
    check("hold_writes_per_txn", n_wr - w0, 4 * rises);
    check("hold_starts_per_txn", n_start - s0, rises);
    check("hold_orbit", ifc.orbit_len, 16'(8 * rises));
    check("hold_path", ifc.path_record, 32'd16);

    check("monitor_anomalies", n_bad, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
